normalization: RTL

NORMALIZATION -- requirements
Module: normalization

---
 rtl/sd4_pkg.sv | 15 +
 rtl/sm_convert.sv | 25 ++
 rtl/normalization.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sd4_pkg.sv
// Shared widths, exponent floor and FSM state encoding for the normalization datapath.
package sd4_pkg;

    localparam int SUM_W   = 16;
    localparam int MANT_W  = 4;
    localparam int EXP_W   = 5;
    localparam int EXP_MIN = -16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sm_convert.sv
// Two's-complement to sign-magnitude conversion of the aligned sum.
module sm_convert #(
    parameter int SUM_W = sd4_pkg::SUM_W
) (
    input  logic [SUM_W-1:0] sum_i,
    output logic             sign_o,
    output logic [SUM_W-2:0] mag_o,
    output logic             is_min_o
);

    logic [SUM_W-1:0] neg_s;

    // The most negative value has no positive counterpart in SUM_W-1 bits, so it is flagged separately.
    always_comb begin
        neg_s    = (~sum_i) + {{(SUM_W-1){1'b0}}, 1'b1};
        sign_o   = sum_i[SUM_W-1];
        is_min_o = (sum_i == {1'b1, {(SUM_W-1){1'b0}}});
        if (sum_i[SUM_W-1]) begin
            mag_o = neg_s[SUM_W-2:0];
        end else begin
            mag_o = sum_i[SUM_W-2:0];
        end
    end

endmodule

// File: rtl/normalization.sv
// Normalizes an aligned two's-complement sum into a sign-magnitude mantissa and signed exponent,
// shifting one bit per cycle and flushing to zero on exponent underflow.
module normalization #(
    parameter int SUM_W  = sd4_pkg::SUM_W,
    parameter int MANT_W = sd4_pkg::MANT_W,
    parameter int EXP_W  = sd4_pkg::EXP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SUM_W-1:0]  aligned_sum,
    input  logic [EXP_W-1:0]  exp_max,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W:0]   signed_pp,
    output logic [EXP_W-1:0]  exp,
    output logic              zero,
    output logic              ovf,
    output logic              uflow
);

    import sd4_pkg::*;

    localparam int               MAG_W     = SUM_W - 1;
    localparam logic [EXP_W-1:0] EXP_MIN_V = EXP_W'(EXP_MIN);

    state_e             state_q, state_d;
    logic [MAG_W-1:0]   mag_q, mag_d, mag_sh_s;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               sign_q, sign_d;
    logic [MANT_W:0]    pp_q, pp_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               uflow_q, uflow_d;
    logic               cv_sign_s;
    logic [MAG_W-1:0]   cv_mag_s;
    logic               cv_min_s;

    sm_convert #(.SUM_W(SUM_W)) u_sm_convert (
        .sum_i    (aligned_sum),
        .sign_o   (cv_sign_s),
        .mag_o    (cv_mag_s),
        .is_min_o (cv_min_s)
    );

    // State, datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mag_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            pp_q    <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            pp_q    <= pp_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            uflow_q <= uflow_d;
        end
    end

    // Next-state and datapath update; result registers only change on the way into DONE.
    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        pp_d     = pp_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        uflow_d  = uflow_q;
        mag_sh_s = {mag_q[MAG_W-2:0], 1'b0};
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = cv_sign_s;
                    mag_d   = cv_mag_s;
                    exp_d   = exp_max;
                    pp_d    = '0;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    uflow_d = 1'b0;
                    if (cv_min_s) begin
                        ovf_d   = 1'b1;
                        pp_d    = {1'b1, {MANT_W{1'b1}}};
                        state_d = DONE;
                    end else if (cv_mag_s == {MAG_W{1'b0}}) begin
                        zero_d  = 1'b1;
                        exp_d   = '0;
                        state_d = DONE;
                    end else if (cv_mag_s[MAG_W-1]) begin
                        pp_d    = {cv_sign_s, cv_mag_s[MAG_W-1 -: MANT_W]};
                        state_d = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            NORM: begin
                // Already at the exponent floor: one more shift would underflow.
                if (exp_q == EXP_MIN_V) begin
                    pp_d    = '0;
                    exp_d   = '0;
                    zero_d  = 1'b1;
                    uflow_d = 1'b1;
                    state_d = DONE;
                end else begin
                    mag_d = mag_sh_s;
                    exp_d = exp_q - {{(EXP_W-1){1'b0}}, 1'b1};
                    if (mag_sh_s[MAG_W-1]) begin
                        pp_d    = {sign_q, mag_sh_s[MAG_W-1 -: MANT_W]};
                        state_d = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign signed_pp = pp_q;
    assign exp       = exp_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign uflow     = uflow_q;

endmodule
